// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: ratio-load handshake and divided-clock outputs of clk_div_ctrl
interface clk_div_ctrl_if #(parameter int DIV_W = 8);
    logic             i_clk_en;
    logic [DIV_W-1:0] i_div_ratio;
    logic             i_ratio_load;
    logic             o_ratio_ack;
    logic             o_busy;
    logic             o_div_clk;
    logic             o_div_tick;
    modport master (output i_clk_en, i_div_ratio, i_ratio_load,
                    input  o_ratio_ack, o_busy, o_div_clk, o_div_tick);
    modport slave  (input  i_clk_en, i_div_ratio, i_ratio_load,
                    output o_ratio_ack, o_busy, o_div_clk, o_div_tick);
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free integer clock divider with boundary-synchronous ratio reload; CLK_DIV_TICK_EN adds a period-start tick
module clk_div_ctrl #(parameter int DIV_W = 8) (
    input logic         i_ref_clk,
    input logic         i_rst,
    clk_div_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t           state, nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt, r_act, pend, hi_last, lo_last, new_act;
    logic             busy, ack, div_q, boundary, apply;
    assign hi_last  = (r_act >> 1) + DIV_W'(r_act[0]) - DIV_W'(1);
    assign lo_last  = (r_act >> 1) - DIV_W'(1);
    assign boundary = state == LOW && cnt == lo_last;
    assign apply    = busy && (state == IDLE || boundary);
    assign new_act  = apply ? pend : r_act;
    assign bus.o_ratio_ack = ack;
    assign bus.o_busy      = busy;
    assign bus.o_div_clk   = state == IDLE ? i_ref_clk : div_q;
    // next state and phase counter; a ratio applied from IDLE takes effect before the first HIGH
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt + DIV_W'(1);
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.i_clk_en && r_act >= DIV_W'(2) && !apply) nxt = HIGH;
            end
            HIGH: if (cnt == hi_last) begin
                nxt     = LOW;
                cnt_nxt = '0;
            end
            LOW: if (boundary) begin
                nxt     = (bus.i_clk_en && new_act >= DIV_W'(2)) ? HIGH : IDLE;
                cnt_nxt = '0;
            end
            default: begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end
        endcase
    end
    // state, ratio registers and the registered clock level
    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            r_act <= '0;
            pend  <= '0;
            busy  <= 1'b0;
            ack   <= 1'b0;
            div_q <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            r_act <= new_act;
            ack   <= apply;
            div_q <= nxt == HIGH;
            busy  <= bus.i_ratio_load || (busy && !apply);
            if (bus.i_ratio_load) pend <= bus.i_div_ratio;
        end
    end
`ifdef CLK_DIV_TICK_EN
    logic tick;
    assign bus.o_div_tick = tick;
    // tick marks the first ref cycle of every HIGH phase
    always_ff @(posedge i_ref_clk) begin
        tick <= !i_rst && nxt == HIGH && state != HIGH;
    end
`else
    assign bus.o_div_tick = 1'b0;
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scenario and randomized checks of clk_div_ctrl against a period-position model
module tb_clk_div_ctrl;
    localparam int DIV_W = 8;
`ifdef CLK_DIV_TICK_EN
    localparam bit TICK = 1'b1;
`else
    localparam bit TICK = 1'b0;
`endif
    logic ref_clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_pass = 0;
    bit   m_run, m_busy, m_ack;
    int   m_pos, m_act, m_pend;
    clk_div_ctrl_if #(.DIV_W(DIV_W)) bus ();
    clk_div_ctrl #(.DIV_W(DIV_W)) dut (.i_ref_clk(ref_clk), .i_rst(rst), .bus(bus.slave));
    always #5 ref_clk = ~ref_clk;
    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1);
    end
    function automatic bit e_clk(input bit lvl);
        return m_run ? (m_pos < (m_act + 1) / 2) : lvl;
    endfunction
    function automatic bit e_tick();
        return TICK && m_run && m_pos == 0;
    endfunction
    task automatic step();
        bit bnd, ap;
        int nact;
        @(posedge ref_clk);
        if (rst) begin
            m_run = 0; m_pos = 0; m_act = 0; m_pend = 0; m_busy = 0; m_ack = 0;
        end else begin
            bnd  = m_run && m_pos == m_act - 1;
            ap   = m_busy && (!m_run || bnd);
            nact = ap ? m_pend : m_act;
            if (m_run) begin
                if (bnd) begin
                    m_run = bus.i_clk_en && nact >= 2;
                    m_pos = 0;
                end else m_pos++;
            end else if (bus.i_clk_en && m_act >= 2 && !ap) begin
                m_run = 1;
                m_pos = 0;
            end
            m_ack  = ap;
            m_act  = nact;
            if (bus.i_ratio_load) m_pend = int'(bus.i_div_ratio);
            m_busy = bus.i_ratio_load || (m_busy && !ap);
        end
        #1;
    endtask
    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask
    task automatic load(input int n);
        bus.i_div_ratio = DIV_W'(n); bus.i_ratio_load = 1; step(); bus.i_ratio_load = 0;
    endtask
    task automatic test_reset();
        bus.i_clk_en = 1; bus.i_div_ratio = 4; bus.i_ratio_load = 1;
        rst = 1; step(); step();
        n_chk++; if ({bus.o_busy, bus.o_ratio_ack, bus.o_div_tick} !== 3'b000) $display("FAIL reset_outs: got %b required 000", {bus.o_busy, bus.o_ratio_ack, bus.o_div_tick}); else n_pass++;
        n_chk++; if (bus.o_div_clk !== 1'b1) $display("FAIL reset_clk_hi: got %b required 1", bus.o_div_clk); else n_pass++;
        @(negedge ref_clk); #1;
        n_chk++; if (bus.o_div_clk !== 1'b0) $display("FAIL reset_clk_lo: got %b required 0", bus.o_div_clk); else n_pass++;
        bus.i_ratio_load = 0; rst = 0;
        step();
        n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL reset_prio_busy: got %b required 0", bus.o_busy); else n_pass++;
    endtask
    task automatic test_div4();
        logic [11:0] pat;
        do_reset(); bus.i_clk_en = 1; load(4);
        n_chk++; if (bus.o_busy !== 1'b1) $display("FAIL div4_busy: got %b required 1", bus.o_busy); else n_pass++;
        step();
        n_chk++; if ({bus.o_ratio_ack, bus.o_busy} !== 2'b10) $display("FAIL div4_ack: got %b required 10", {bus.o_ratio_ack, bus.o_busy}); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            step(); pat = {pat[10:0], bus.o_div_clk};
            n_chk++; if (bus.o_div_clk !== e_clk(1'b1)) $display("FAIL div4_clk c%0d: got %b required %b", i, bus.o_div_clk, e_clk(1'b1)); else n_pass++;
        end
        n_chk++; if (pat !== 12'b110011001100) $display("FAIL div4_pattern: got %b required 110011001100", pat); else n_pass++;
    endtask
    task automatic test_div5();
        logic [14:0] pat;
        int ticks = 0;
        do_reset(); bus.i_clk_en = 1; load(5); step();
        for (int i = 0; i < 15; i++) begin
            step(); pat = {pat[13:0], bus.o_div_clk}; ticks += int'(bus.o_div_tick);
            n_chk++; if (bus.o_div_tick !== e_tick()) $display("FAIL div5_tick c%0d: got %b required %b", i, bus.o_div_tick, e_tick()); else n_pass++;
        end
        n_chk++; if (pat !== 15'b111001110011100) $display("FAIL div5_pattern: got %b required 111001110011100", pat); else n_pass++;
        n_chk++; if (ticks !== (TICK ? 3 : 0)) $display("FAIL div5_tick_count: got %0d required %0d", ticks, TICK ? 3 : 0); else n_pass++;
    endtask
    task automatic test_reload();
        logic [9:0] pc, pb, pa;
        do_reset(); bus.i_clk_en = 1; load(4); step(); step();
        load(6);
        for (int i = 0; i < 10; i++) begin
            pc = {pc[8:0], bus.o_div_clk}; pb = {pb[8:0], bus.o_busy}; pa = {pa[8:0], bus.o_ratio_ack};
            n_chk++; if ({bus.o_div_clk, bus.o_busy, bus.o_ratio_ack} !== {e_clk(1'b1), m_busy, m_ack}) $display("FAIL reload_model c%0d: got %b required %b", i, {bus.o_div_clk, bus.o_busy, bus.o_ratio_ack}, {e_clk(1'b1), m_busy, m_ack}); else n_pass++;
            step();
        end
        n_chk++; if (pc !== 10'b1001110001) $display("FAIL reload_clk: got %b required 1001110001", pc); else n_pass++;
        n_chk++; if (pb !== 10'b1110000000) $display("FAIL reload_busy: got %b required 1110000000", pb); else n_pass++;
        n_chk++; if (pa !== 10'b0001000000) $display("FAIL reload_ack: got %b required 0001000000", pa); else n_pass++;
    endtask
    task automatic test_en_drop();
        logic [11:0] pat;
        do_reset(); bus.i_clk_en = 1; load(8); step(); step(); step();
        bus.i_clk_en = 0;
        for (int i = 0; i < 12; i++) begin
            step(); pat = {pat[10:0], bus.o_div_clk};
            @(negedge ref_clk); #1;
            n_chk++; if (bus.o_div_clk !== e_clk(1'b0)) $display("FAIL endrop_neg c%0d: got %b required %b", i, bus.o_div_clk, e_clk(1'b0)); else n_pass++;
        end
        n_chk++; if (pat !== 12'b110000111111) $display("FAIL endrop_pattern: got %b required 110000111111", pat); else n_pass++;
    endtask
    task automatic test_bypass();
        do_reset(); bus.i_clk_en = 0; load(1); step();
        n_chk++; if (bus.o_ratio_ack !== 1'b1) $display("FAIL bypass_ack: got %b required 1", bus.o_ratio_ack); else n_pass++;
        bus.i_clk_en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++; if (bus.o_div_clk !== 1'b1) $display("FAIL bypass_hi c%0d: got %b required 1", i, bus.o_div_clk); else n_pass++;
            @(negedge ref_clk); #1;
            n_chk++; if (bus.o_div_clk !== 1'b0) $display("FAIL bypass_lo c%0d: got %b required 0", i, bus.o_div_clk); else n_pass++;
        end
        bus.i_clk_en = 0; load(4); step();
        n_chk++; if ({bus.o_ratio_ack, bus.o_busy} !== 2'b10) $display("FAIL bypass_en0_ack: got %b required 10", {bus.o_ratio_ack, bus.o_busy}); else n_pass++;
        step(); @(negedge ref_clk); #1;
        n_chk++; if (bus.o_div_clk !== 1'b0) $display("FAIL bypass_en0_clk: got %b required 0", bus.o_div_clk); else n_pass++;
    endtask
    task automatic test_rst_mid();
        do_reset(); bus.i_clk_en = 1; load(4); step(); step(); load(6);
        n_chk++; if ({bus.o_div_clk, bus.o_busy} !== 2'b11) $display("FAIL rstmid_pre: got %b required 11", {bus.o_div_clk, bus.o_busy}); else n_pass++;
        rst = 1; step(); rst = 0;
        n_chk++; if ({bus.o_busy, bus.o_ratio_ack} !== 2'b00) $display("FAIL rstmid_busy: got %b required 00", {bus.o_busy, bus.o_ratio_ack}); else n_pass++;
        @(negedge ref_clk); #1;
        n_chk++; if (bus.o_div_clk !== 1'b0) $display("FAIL rstmid_clk: got %b required 0", bus.o_div_clk); else n_pass++;
        step(); step(); @(negedge ref_clk); #1;
        n_chk++; if (bus.o_div_clk !== 1'b0) $display("FAIL rstmid_idle: got %b required 0", bus.o_div_clk); else n_pass++;
    endtask
    task automatic test_max();
        int highs = 0;
        do_reset(); bus.i_clk_en = 1; load(255); step();
        for (int i = 0; i < 520; i++) begin
            step();
            if (i < 255) highs += int'(bus.o_div_clk);
            n_chk++; if (bus.o_div_clk !== e_clk(1'b1)) $display("FAIL max_clk c%0d: got %b required %b", i, bus.o_div_clk, e_clk(1'b1)); else n_pass++;
        end
        n_chk++; if (highs !== 128) $display("FAIL max_high_count: got %0d required 128", highs); else n_pass++;
    endtask
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = $urandom_range(0, 199) == 0;
            bus.i_clk_en = $urandom_range(0, 15) != 0;
            bus.i_ratio_load = $urandom_range(0, 11) == 0;
            bus.i_div_ratio = DIV_W'($urandom_range(0, 11));
            step();
            n_chk++; if ({bus.o_div_clk, bus.o_busy, bus.o_ratio_ack, bus.o_div_tick} !== {e_clk(1'b1), m_busy, m_ack, e_tick()}) $display("FAIL rand_pos c%0d: got %b required %b", i, {bus.o_div_clk, bus.o_busy, bus.o_ratio_ack, bus.o_div_tick}, {e_clk(1'b1), m_busy, m_ack, e_tick()}); else n_pass++;
            @(negedge ref_clk); #1;
            n_chk++; if (bus.o_div_clk !== e_clk(1'b0)) $display("FAIL rand_neg c%0d: got %b required %b", i, bus.o_div_clk, e_clk(1'b0)); else n_pass++;
        end
        rst = 0; bus.i_ratio_load = 0;
    endtask
    initial begin
        bus.i_clk_en = 0; bus.i_div_ratio = '0; bus.i_ratio_load = 0;
        test_reset();
        test_div4();
        test_div5();
        test_reload();
        test_en_drop();
        test_bypass();
        test_rst_mid();
        test_max();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning the width of the divide ratio and phase counter.
REQ-002 SHALL have port i_ref_clk, input, 1 bit: the reference clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i_clk_en, input, 1 bit: divider enable.
REQ-005 SHALL have port i_div_ratio, input, DIV_W bits: requested divide ratio N.
REQ-006 SHALL have port i_ratio_load, input, 1 bit: one-cycle pulse that captures i_div_ratio as a pending request.
REQ-007 SHALL have port o_ratio_ack, output, 1 bit: one-cycle pulse in the cycle the pending ratio becomes active.
REQ-008 SHALL have port o_busy, output, 1 bit: high while a captured request is not yet applied.
REQ-009 SHALL have port o_div_clk, output, 1 bit: the divided clock, or i_ref_clk in bypass.
REQ-010 SHALL have port o_div_tick, output, 1 bit: the period-start strobe (see Configuration).

Function
REQ-011 SHALL implement a three-state FSM: IDLE (bypass), HIGH and LOW; r_act holds the active ratio and a DIV_W-bit phase counter times each phase.
REQ-012 SHALL drive o_div_clk = i_ref_clk combinationally in IDLE; in HIGH it SHALL be 1 and in LOW it SHALL be 0, both from registers.
REQ-013 SHALL make HIGH last ceil(N/2) and LOW last floor(N/2) ref cycles, giving period N and exactly 50% duty for even N.
REQ-014 SHALL move IDLE->HIGH, with counter = 0, on the first edge where i_clk_en = 1 and r_act >= 2.
REQ-015 SHALL move HIGH->LOW when the counter reaches ceil(r_act/2)-1, and LOW->HIGH when it reaches floor(r_act/2)-1, clearing the counter at each transition.
REQ-016 SHALL set pending = i_div_ratio and o_busy = 1 one cycle after i_ratio_load; a later load before application SHALL overwrite pending (last wins).
REQ-017 SHALL define the period boundary as the last cycle of LOW.
REQ-018 SHALL apply pending to r_act only at the period boundary, or on the next edge when in IDLE; it SHALL assert o_ratio_ack for one cycle and clear o_busy on that edge.
REQ-019 SHALL let a load in the same cycle as application win: it becomes the new pending and o_busy stays 1.
REQ-020 SHALL, on i_clk_en = 0 while in HIGH or LOW, complete the current period and enter IDLE at the boundary; it SHALL never truncate a phase.
REQ-021 SHALL enter IDLE at the boundary when the ratio applied there is 0 or 1.
REQ-022 SHALL size all counter and compare arithmetic at DIV_W bits, so that N = 2**DIV_W-1 works without overflow.

Reset
REQ-023 SHALL, when i_rst = 1 on a rising edge, set state = IDLE, counter = 0, r_act = 0, pending = 0, o_busy = 0, o_ratio_ack = 0 and o_div_tick = 0.
REQ-024 SHALL, on reset mid-period, abandon the period immediately; o_div_clk SHALL follow i_ref_clk from the next edge.
REQ-025 SHALL give reset priority over i_ratio_load and i_clk_en.

Configuration
REQ-026 SHALL use macro CLK_DIV_TICK_EN to compile the tick logic in or out.
REQ-027 SHALL, with CLK_DIV_TICK_EN defined, register o_div_tick high for exactly one ref cycle in the first cycle of every HIGH phase.
REQ-028 SHALL, without CLK_DIV_TICK_EN, tie o_div_tick to 0 and implement no tick logic.

Verification
REQ-029 SHALL cover: reset, en = 1, load N = 4 -> ack after 1 cycle; o_div_clk repeats 2 high / 2 low.
REQ-030 SHALL cover: load N = 5 -> 3 high / 2 low, period 5; with macro defined, o_div_tick pulses once every 5 cycles.
REQ-031 SHALL cover: running N = 4, load N = 6 in the 1st HIGH cycle -> o_busy = 1 until the end of the current LOW; ack at the boundary; next period 3 high / 3 low.
REQ-032 SHALL cover: N = 1, or en = 0 from reset -> o_div_clk equals i_ref_clk; o_ratio_ack still pulses on load.
REQ-033 SHALL cover: N = 8, en dropped in the 2nd HIGH cycle -> full 4 high / 4 low completes, then bypass.
REQ-034 SHALL cover: i_rst asserted mid-HIGH with pending loaded -> next edge IDLE, o_busy = 0, bypass output.
